// File: rtl/div_unit.sv
// div_unit: iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
//
// Restoring division with one shift-subtract step per clock and XLEN steps per operation.
// Signed operations divide the operand magnitudes, then fix up the signs. The RISC-V
// divide-by-zero and signed-overflow cases skip the iteration and finish one cycle after
// the request is accepted.
//
// Ports:
//   clk     in   1     single clock, rising edge
//   rst     in   1     synchronous reset, active-high; aborts any operation in flight
//   start   in   1     request; sampled only when not busy
//   op      in   2     funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   a       in   XLEN  dividend (rs1)
//   b       in   XLEN  divisor (rs2)
//   busy    out  1     iteration in progress; start ignored
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  quotient or remainder; held until the next result is written
module div_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e            state_q;
    logic [XLEN-1:0]   dvd_q;     // dividend magnitude; quotient bits shift in at the LSB
    logic [XLEN-1:0]   dsr_q;     // divisor magnitude
    logic [XLEN-1:0]   rem_q;     // partial remainder
    logic [CntW-1:0]   cnt_q;     // steps remaining
    logic              q_neg_q;
    logic              r_neg_q;
    logic              is_rem_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Request decode, evaluated on the raw inputs at the accepting edge.
    logic              signed_op;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              b_zero;
    logic              ovf;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[XLEN-1];
        b_neg     = signed_op & b[XLEN-1];
        // -MinVal wraps to MinVal, which is still the correct unsigned magnitude.
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        b_zero    = (b == '0);
        ovf       = signed_op & (a == MinVal) & (b == '1);
        fast_res  = '0;
        if (b_zero) begin
            fast_res = op[1] ? a : '1;
        end else begin
            fast_res = op[1] ? '0 : a;
        end
    end

    // One restoring step. The shifted remainder needs XLEN+1 bits because an unsigned
    // divisor can be as large as 2^XLEN-1; the borrow out of the subtraction is the
    // inverted quotient bit.
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic              q_bit;
    logic [XLEN-1:0]   rem_nx;
    logic [XLEN-1:0]   dvd_nx;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        rem_sh    = {rem_q, dvd_q[XLEN-1]};
        diff      = rem_sh - {1'b0, dsr_q};
        q_bit     = ~diff[XLEN];
        rem_nx    = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        dvd_nx    = {dvd_q[XLEN-2:0], q_bit};
        quo_fix   = q_neg_q ? -dvd_nx : dvd_nx;
        rem_fix   = r_neg_q ? -rem_nx : rem_nx;
        final_res = is_rem_q ? rem_fix : quo_fix;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start) begin
                        q_neg_q  <= a_neg ^ b_neg;
                        r_neg_q  <= a_neg;
                        is_rem_q <= op[1];
                        if (b_zero || ovf) begin
                            result_q <= fast_res;
                            done_q   <= 1'b1;
                            state_q  <= StDone;
                        end else begin
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            rem_q   <= '0;
                            cnt_q   <= CntW'(XLEN);
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StCalc: begin
                    // start is deliberately ignored here and not queued.
                    dvd_q <= dvd_nx;
                    rem_q <= rem_nx;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        result_q <= final_res;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
